lut4_cfg_loader: RTL
====================

# lut4_cfg_loader

Configuration front-end for the LUT4 test core: sits directly upstream of the LUT array and supplies its truth-table bits. Receives a bit-serial configuration stream on three pad-level inputs (data, strobe, latch), synchronises them, shifts bits into a shadow register and commits the shadow to the active LUT configuration on a latch event, but only when exactly the right number of bits has been received. The active configuration drives the LUT4 evaluation logic combinationally. Shifting never disturbs the active configuration.

## Interface
Parameters:
- N_LUTS, 4: number of 4-input LUTs configured; shadow/active width is 16*N_LUTS.
- CFG_RESET, all-zero: reset and power-on value of the active configuration.

Ports:
- clk  in  1  single design clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ena  in  1  design selected; when low, strobe/latch edges are ignored. Synchronisers keep running.
- cfg_data  in  1  serial config bit; asynchronous pad input.
- cfg_strobe  in  1  shift strobe; each rising edge shifts in one bit. Asynchronous pad input.
- cfg_latch  in  1  commit request; acts on its rising edge. Asynchronous pad input.
- lut_cfg  out  16*N_LUTS  active configuration. LUT i uses bits [16*i+15:16*i]; bit index = {d,c,b,a}.
- cfg_valid  out  1  one-cycle pulse on a successful commit.
- cfg_loaded  out  1  sticky high after the first successful commit since reset.
- cfg_err  out  1  sticky error flag; cleared by the next successful commit or by reset.
- bit_count  out  $clog2(16*N_LUTS+1)  bits shifted since the last latch; saturates.

## Operation
- All three pad inputs pass through a 2-flop synchroniser, then a registered edge detector (previous-value flop).
- States: IDLE, SHIFT, COMMIT.
- IDLE: shadow is don't-care and bit_count=0.
  - Strobe edge with ena=1: shift one bit and go to SHIFT.
  - Latch edge: sets cfg_err and stays in IDLE. This is a zero-bit load.
- SHIFT: on each strobe edge, shadow <= {shadow[W-2:0], data_sync}. Data is sampled from the same synchronised sample in which the strobe edge is detected.
  - bit_count increments on each shifted bit.
  - At W=16*N_LUTS, bit_count stops and an internal overflow bit sets. Further bits keep shifting, so the last W bits are retained.
- Latch edge in SHIFT:
  - If bit_count==W and overflow==0: go to COMMIT.
  - Otherwise: set cfg_err, leave lut_cfg unchanged, clear count and overflow, return to IDLE.
- COMMIT (one cycle):
  - lut_cfg <= shadow; cfg_valid=1; cfg_loaded=1; cfg_err=0.
  - Clear count and overflow; go to IDLE.
- Simultaneous strobe and latch edges in the same cycle: latch is processed and the strobe is dropped. The drop also sets cfg_err.
- ena=0: edges are consumed by the detector but cause no action. State, count and lut_cfg hold.
- Bit ordering: the first bit shifted ends at lut_cfg MSB (LUT N_LUTS-1, index 15). The last bit shifted ends at LUT 0, index 0.

## Timing
- Reset values: lut_cfg=CFG_RESET, cfg_valid=0, cfg_loaded=0, cfg_err=0, bit_count=0, state=IDLE, synchroniser and edge flops=0.
- Reset mid-shift or during COMMIT: everything returns to reset values immediately. Partial data is discarded; no commit occurs.
- Pad strobe rise to shadow update: 3 clk edges (2 synchroniser + 1 edge detect/shift).
- Pad latch rise to lut_cfg update and cfg_valid: 4 clk edges (3 to enter COMMIT, +1 for the commit).
- cfg_valid is high exactly one cycle. lut_cfg changes on the same edge that cfg_valid rises.
- Input pulses shorter than 2 clk periods, high or low, are not guaranteed to be detected. This is a source requirement.
- cfg_data must be stable from 2 cycles before to 1 cycle after the strobe rising edge at the pad.

## Structure
- Shared package lut4_pkg:
  - LUT_BITS=16.
  - State enum cfg_state_t {IDLE, SHIFT, COMMIT}.
  - Function for bit_count width.
- Sub-module lut4_sync2: parameterised-width 2-flop synchroniser with async active-low reset. Instantiated once, 3 bits wide.
- The edge detector, FSM and datapath live in lut4_cfg_loader.

## Test plan
- Reset → lut_cfg=CFG_RESET, all flags 0. Strobe pulse while rst_n=0 → no change after release.
- N_LUTS=4: shift 64 bits of 0xCAFE_F00D_1234_8001 MSB-first, then latch → lut_cfg=0xCAFEF00D12348001, one cfg_valid pulse, cfg_loaded=1, cfg_err=0.
- Shift 63 bits, then latch → cfg_err=1, lut_cfg unchanged, bit_count=0. Follow with a correct 64-bit load → cfg_err=0, new value committed.
- Shift 70 bits, then latch → cfg_err=1, no commit, bit_count had saturated at 64.
- ena=0 during 64 strobes and a latch → lut_cfg, bit_count and state unchanged. Re-enable and load 0xFFFF_0000_AAAA_5555 → committed.
- Drive strobe and latch rising together after 63 bits → latch processed, strobe dropped, cfg_err=1. Assert rst_n=0 mid-shift at bit 30 → bit_count=0, lut_cfg=CFG_RESET.

Source files
------------

// File: rtl/lut4_pkg.sv
// Shared types and constants for the LUT4 configuration loader.
// Holds the FSM state encoding and the bit counter width helper.
package lut4_pkg;

  localparam int LUT_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } cfg_state_t;

  function automatic int cnt_width(input int n_luts);
    return $clog2(LUT_BITS * n_luts + 1);
  endfunction

endpackage

// File: rtl/lut4_cfg_loader_if.sv
// Config stream and status bundle between a config source
// (master) and the LUT4 configuration loader (slave).
interface lut4_cfg_loader_if
  import lut4_pkg::*;
#(
  parameter int N_LUTS = 4
);

  localparam int W  = LUT_BITS * N_LUTS;
  localparam int CW = cnt_width(N_LUTS);

  logic          cfg_data;
  logic          cfg_strobe;
  logic          cfg_latch;
  logic [W-1:0]  lut_cfg;
  logic          cfg_valid;
  logic          cfg_loaded;
  logic          cfg_err;
  logic [CW-1:0] bit_count;

  modport master (
    output cfg_data,
    output cfg_strobe,
    output cfg_latch,
    input  lut_cfg,
    input  cfg_valid,
    input  cfg_loaded,
    input  cfg_err,
    input  bit_count
  );

  modport slave (
    input  cfg_data,
    input  cfg_strobe,
    input  cfg_latch,
    output lut_cfg,
    output cfg_valid,
    output cfg_loaded,
    output cfg_err,
    output bit_count
  );

endinterface

// File: rtl/lut4_sync2.sv
// Parameterised-width two-flop synchroniser for asynchronous
// pad inputs, cleared by the async active-low reset.
module lut4_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lut4_cfg_loader.sv
// Bit-serial configuration loader: shifts a shadow register and
// commits it to the active LUT configuration on a clean latch.
module lut4_cfg_loader
  import lut4_pkg::*;
#(
  parameter int                         N_LUTS    = 4,
  parameter logic [LUT_BITS*N_LUTS-1:0] CFG_RESET = '0
) (
  input logic             clk,
  input logic             rst_n,
  input logic             ena,
  lut4_cfg_loader_if.slave cfg
);

  localparam int W  = LUT_BITS * N_LUTS;
  localparam int CW = cnt_width(N_LUTS);

  logic [2:0]    pad_s;
  logic          data_s;
  logic          strobe_s;
  logic          latch_s;
  logic          strobe_q;
  logic          latch_q;
  logic          strobe_e;
  logic          latch_e;

  cfg_state_t    state;
  cfg_state_t    state_nx;

  logic [W-1:0]  shadow;
  logic [W-1:0]  lut_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          valid_q;
  logic          loaded_q;
  logic          err_q;
  logic          cnt_full;

  logic          do_shift;
  logic          do_commit;
  logic          set_err;
  logic          clr_cnt;

  lut4_sync2 #(
    .WIDTH (3)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({cfg.cfg_latch, cfg.cfg_strobe, cfg.cfg_data}),
    .q     (pad_s)
  );

  assign data_s   = pad_s[0];
  assign strobe_s = pad_s[1];
  assign latch_s  = pad_s[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      latch_q  <= 1'b0;
    end else begin
      strobe_q <= strobe_s;
      latch_q  <= latch_s;
    end
  end

  // Edges are consumed regardless of ena; ena only gates the action
  assign strobe_e = strobe_s & ~strobe_q;
  assign latch_e  = latch_s & ~latch_q;
  assign cnt_full = (cnt_q == CW'(W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (ena && !latch_e && strobe_e) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (ena && latch_e) begin
          state_nx = (cnt_full && !ovf_q) ? COMMIT : IDLE;
        end
      end
      COMMIT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    do_shift  = 1'b0;
    do_commit = 1'b0;
    set_err   = 1'b0;
    clr_cnt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ena && latch_e) begin
          set_err = 1'b1;
        end else if (ena && strobe_e) begin
          do_shift = 1'b1;
        end
      end
      SHIFT: begin
        if (ena && latch_e) begin
          clr_cnt = 1'b1;
          // A strobe landing with the latch is dropped and flagged
          set_err = strobe_e || !cnt_full || ovf_q;
        end else if (ena && strobe_e) begin
          do_shift = 1'b1;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        clr_cnt   = 1'b1;
      end
      default: begin
        clr_cnt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (do_shift) begin
      shadow <= {shadow[W-2:0], data_s};
      if (cnt_full) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q    <= CFG_RESET;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= do_commit;
      if (do_commit) begin
        lut_q    <= shadow;
        loaded_q <= 1'b1;
        err_q    <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cfg.lut_cfg    = lut_q;
  assign cfg.cfg_valid  = valid_q;
  assign cfg.cfg_loaded = loaded_q;
  assign cfg.cfg_err    = err_q;
  assign cfg.bit_count  = cnt_q;

endmodule
